// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA command sequencer: opcodes, FSM encoding
// and the packed command record stored in the command FIFO.
package vga_seq_pkg;

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_FILL     = 2'b01;
  localparam logic [1:0] OP_CLEAR    = 2'b10;
  localparam logic [1:0] OP_FILL_ROW = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam int CMD_W = 18;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] pos;
    logic [7:0] value;
  } cmd_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; rst_n flushes it asynchronously.
module vga_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_cmd_seq.sv
// Expands buffered display commands into single-cycle cell-write beats.
// Optional write_count output is enabled by defining VGA_SEQ_WRITE_COUNT_EN.
module vga_cmd_seq
  import vga_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CELLS  = 16,
  parameter int ROW_CELLS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_pos,
  input  logic [7:0]  cmd_value,
  output logic        write_enable,
  output logic [7:0]  position,
  output logic [7:0]  value,
  output logic        busy,
  output logic        err_oor,
  output logic [0:0]  dbg_state
`ifdef VGA_SEQ_WRITE_COUNT_EN
  ,
  output logic [15:0] write_count
`endif
);

  // Handshake: a command is accepted on any edge with cmd_valid && cmd_ready;
  // cmd_ready is simply !full and never looks at cmd_valid.

  localparam logic [7:0] LAST_CELL = 8'(NUM_CELLS - 1);
  localparam logic [7:0] LAST_ROW  = 8'(ROW_CELLS - 1);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CMD_W-1:0] fifo_dout;
  cmd_t             head;

  logic [0:0] state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] val_q, val_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] term_q, term_d;
  logic       err_q, err_d;
  logic       final_beat;

  assign fifo_push = cmd_valid && !fifo_full;
  assign head      = cmd_t'(fifo_dout);

  vga_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({cmd_op, cmd_pos, cmd_value}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign final_beat = (state_q == ST_ISSUE) && (cnt_q == term_q);

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    pos_d    = pos_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    if (state_q == ST_ISSUE && !final_beat) begin
      we_d  = 1'b1;
      cnt_d = cnt_q + 8'd1;
      pos_d = pos_q + 8'd1;
    end else if (!fifo_empty) begin
      // Idle, or last beat of the previous command: start the head with no bubble.
      fifo_pop = 1'b1;
      we_d     = 1'b1;
      state_d  = ST_ISSUE;
      cnt_d    = 8'd0;
      val_d    = head.value;
      case (head.op)
        OP_WRITE: begin
          pos_d  = head.pos;
          term_d = 8'd0;
          if (head.pos > LAST_CELL) begin
            we_d    = 1'b0;
            state_d = ST_IDLE;
            err_d   = 1'b1;
            pos_d   = pos_q;
            val_d   = val_q;
          end
        end
        OP_FILL: begin
          pos_d  = 8'd0;
          term_d = LAST_CELL;
        end
        OP_CLEAR: begin
          pos_d  = 8'd0;
          val_d  = 8'h00;
          term_d = LAST_CELL;
        end
        default: begin
          pos_d  = {4'd0, head.pos[3:2], 2'b00};
          term_d = LAST_ROW;
        end
      endcase
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      pos_q   <= 8'd0;
      val_q   <= 8'd0;
      cnt_q   <= 8'd0;
      term_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      pos_q   <= pos_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign write_enable = we_q;
  assign position     = pos_q;
  assign value        = val_q;
  assign err_oor      = err_q;
  assign busy         = !fifo_empty || we_q || (state_q != ST_IDLE);
  assign dbg_state    = state_q;

`ifdef VGA_SEQ_WRITE_COUNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (we_q && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= 16'd0;
    else        wcnt_q <= wcnt_d;
  end

  assign write_count = wcnt_q;
`endif

endmodule

// File: tb/tb_vga_cmd_seq.sv
// Self-checking bench for vga_cmd_seq: vector table, directed corner cases and
// randomized traffic against a beat-list reference model.
module tb_vga_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_pos;
  logic [7:0]  cmd_value;
  logic        write_enable;
  logic [7:0]  position;
  logic [7:0]  value;
  logic        busy;
  logic        err_oor;
  logic [0:0]  dbg_state;
`ifdef VGA_SEQ_WRITE_COUNT_EN
  logic [15:0] write_count;
`endif

  vga_cmd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_pos      (cmd_pos),
    .cmd_value    (cmd_value),
    .write_enable (write_enable),
    .position     (position),
    .value        (value),
    .busy         (busy),
    .err_oor      (err_oor),
    .dbg_state    (dbg_state)
`ifdef VGA_SEQ_WRITE_COUNT_EN
    ,
    .write_count  (write_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic        exp_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          beat_total = 0;
  int          beats_since_rst = 0;
  int          first_cyc, last_cyc;

  typedef struct {
    logic [1:0] op;
    logic [7:0] pos;
    logic [7:0] val;
    logic       exp_we;
    logic [7:0] exp_pos;
    logic [7:0] exp_val;
    int         exp_beats;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance to the next negedge and score any beat presented there.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n && write_enable) begin
      beat_total++;
      beats_since_rst++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {16'd0, position, value}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat", {16'd0, position, value}, {16'd0, e});
      end
    end
  endtask

  // Reference model: the list of cell writes a command must produce.
  task automatic model_push(input logic [1:0] op, input logic [7:0] pos, input logic [7:0] val);
    case (op)
      2'b00: begin
        if (pos < 8'd16) exp_q.push_back({pos, val});
        else exp_err = 1'b1;
      end
      2'b01: for (int i = 0; i < 16; i++) exp_q.push_back({8'(i), val});
      2'b10: for (int i = 0; i < 16; i++) exp_q.push_back({8'(i), 8'h00});
      default: for (int k = 0; k < 4; k++) exp_q.push_back({8'(int'(pos[3:2]) * 4 + k), val});
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] pos, input logic [7:0] val);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_pos   = pos;
    cmd_value = val;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    else model_push(op, pos, val);
  endtask

  task automatic wait_idle(output int ticks);
    ticks = 0;
    while (busy && ticks < 400) begin
      tick();
      ticks++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  int b0, nt;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_pos   = 8'd0;
    cmd_value = 8'd0;
    exp_err   = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;

    vecs[0] = '{2'b00, 8'd5,    8'hE0, 1'b1, 8'd5,  8'hE0, 1,  1'b0};
    vecs[1] = '{2'b01, 8'd99,   8'h1C, 1'b1, 8'd0,  8'h1C, 16, 1'b0};
    vecs[2] = '{2'b11, 8'h08,   8'h03, 1'b1, 8'd8,  8'h03, 4,  1'b0};
    vecs[3] = '{2'b10, 8'h77,   8'hAA, 1'b1, 8'd0,  8'h00, 16, 1'b0};
    vecs[4] = '{2'b11, 8'hF4,   8'h55, 1'b1, 8'd4,  8'h55, 4,  1'b0};
    vecs[5] = '{2'b11, 8'h0E,   8'h66, 1'b1, 8'd12, 8'h66, 4,  1'b0};
    vecs[6] = '{2'b00, 8'd15,   8'h7F, 1'b1, 8'd15, 8'h7F, 1,  1'b0};
    vecs[7] = '{2'b00, 8'd20,   8'h44, 1'b0, 8'd0,  8'h00, 0,  1'b1};
    vecs[8] = '{2'b00, 8'd0,    8'h11, 1'b1, 8'd0,  8'h11, 1,  1'b1};
    vecs[9] = '{2'b00, 8'd16,   8'h22, 1'b0, 8'd0,  8'h00, 0,  1'b1};

    // ---- reset state ----
    repeat (3) tick();
    check("rst_write_enable", {31'd0, write_enable}, 32'd0);
    check("rst_position", {24'd0, position}, 32'd0);
    check("rst_value", {24'd0, value}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_oor", {31'd0, err_oor}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    beats_since_rst = 0;
    repeat (2) tick();

    // ---- table: one command at a time into an idle block ----
    for (int i = 0; i < 10; i++) begin
      b0 = beat_total;
      send(vecs[i].op, vecs[i].pos, vecs[i].val);
      check($sformatf("v%0d_no_beat_before_pop", i), {31'd0, write_enable}, 32'd0);
      tick();
      check($sformatf("v%0d_first_we", i), {31'd0, write_enable}, {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d_state", i), {31'd0, dbg_state}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_first_pos", i), {24'd0, position}, {24'd0, vecs[i].exp_pos});
        check($sformatf("v%0d_first_val", i), {24'd0, value}, {24'd0, vecs[i].exp_val});
      end
      wait_idle(nt);
      check($sformatf("v%0d_busy_cycles", i), nt, vecs[i].exp_beats);
      check($sformatf("v%0d_beats", i), beat_total - b0, vecs[i].exp_beats);
      check($sformatf("v%0d_err_oor", i), {31'd0, err_oor}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_queue_drained", i), exp_q.size(), 0);
      tick();
    end

    // ---- back-to-back: FILL + four WRITEs, FIFO fills, no bubbles ----
    b0 = beat_total;
    first_cyc = -1;
    send(2'b01, 8'd0, 8'h3A);
    for (int k = 1; k <= 4; k++) send(2'b00, 8'(k + 9), 8'(8'hB0 + k));
    check("b2b_ready_low_when_full", {31'd0, cmd_ready}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(nt);
    check("b2b_beats", beat_total - b0, 20);
    check("b2b_no_gaps", last_cyc - first_cyc + 1, 20);
    check("b2b_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("b2b_queue_drained", exp_q.size(), 0);

    // ---- FILL_ROW then CLEAR queued together ----
    b0 = beat_total;
    first_cyc = -1;
    send(2'b11, 8'h08, 8'h03);
    send(2'b10, 8'h00, 8'hFF);
    wait_idle(nt);
    check("row_clear_beats", beat_total - b0, 20);
    check("row_clear_no_gaps", last_cyc - first_cyc + 1, 20);
    check("row_clear_drained", exp_q.size(), 0);

`ifdef VGA_SEQ_WRITE_COUNT_EN
    check("write_count_total", {16'd0, write_count}, beats_since_rst);
`endif

    // ---- reset in the middle of a FILL with two commands queued ----
    b0 = beat_total;
    send(2'b01, 8'd0, 8'h5C);
    send(2'b00, 8'd3, 8'h01);
    send(2'b00, 8'd4, 8'h02);
    for (int t = 0; t < 100 && (beat_total - b0) < 7; t++) tick();
    check("mid_reset_reached_beat7", beat_total - b0, 7);
    check("mid_reset_we_before", {31'd0, write_enable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_we_async", {31'd0, write_enable}, 32'd0);
    check("mid_reset_busy_async", {31'd0, busy}, 32'd0);
    check("mid_reset_err_cleared", {31'd0, err_oor}, 32'd0);
    exp_q.delete();
    exp_err = 1'b0;
    tick();
    rst_n = 1'b1;
    beats_since_rst = 0;
    b0 = beat_total;
    repeat (30) tick();
    check("post_reset_no_beats", beat_total - b0, 0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_reset_position", {24'd0, position}, 32'd0);
`ifdef VGA_SEQ_WRITE_COUNT_EN
    check("post_reset_write_count", {16'd0, write_count}, 32'd0);
`endif

    // ---- randomized traffic against the reference model ----
    for (int n = 0; n < 60; n++) begin
      logic [1:0] rop;
      logic [7:0] rpos;
      rop  = 2'($urandom_range(0, 3));
      rpos = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
      send(rop, rpos, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(nt);
    tick();
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_err_oor", {31'd0, err_oor}, {31'd0, exp_err});
    check("rand_busy_end", {31'd0, busy}, 32'd0);
    check("rand_ready_end", {31'd0, cmd_ready}, 32'd1);
`ifdef VGA_SEQ_WRITE_COUNT_EN
    check("rand_write_count", {16'd0, write_count}, beats_since_rst);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_cmd_seq.md
Name: vga_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the VGA colour-cell display.
- The MCU issues high-level display commands: single cell write, fill all, clear all, fill row.
- The block buffers them in a small FIFO and expands each into a stream of single-cycle write_enable/position/value beats.
- The display stage stores one 8-bit colour code per cell in a 4x4 grid, indexed {row[1:0], col[1:0]}.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- NUM_CELLS, 16, number of display cells; legal positions are 0..NUM_CELLS-1.
- ROW_CELLS, 4, cells per row; used by the FILL_ROW expansion.

Ports:
- clk  in  1  system clock (100 MHz domain, same clock as the display stage).
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; high when not full.
- cmd_op  in  2  00 WRITE, 01 FILL, 10 CLEAR, 11 FILL_ROW.
- cmd_pos  in  8  WRITE: cell index; FILL_ROW: row = cmd_pos[3:2]; otherwise ignored.
- cmd_value  in  8  colour code; ignored for CLEAR.
- write_enable  out  1  one beat per cell write, to the display stage.
- position  out  8  cell index of the current beat.
- value  out  8  colour code of the current beat.
- busy  out  1  FIFO non-empty or expansion in progress.
- err_oor  out  1  sticky: a WRITE with cmd_pos >= NUM_CELLS was dropped.

Behaviour:
- Reset: one clock, asynchronous assert, active low (rst_n).
- Reset values: write_enable=0, position=0, value=0, busy=0, err_oor=0, FIFO empty, cmd_ready=1, FSM=IDLE.
- All outputs are registered on posedge clk. The display stage samples on negedge, so it sees values stable for half a cycle.
- Handshake:
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - cmd_ready = !full and is not combinationally dependent on cmd_valid.
  - When full, cmd_ready=0. A pop on edge E raises cmd_ready after E.
  - Push and pop on the same edge are legal when not full; count is unchanged.
- FSM states: IDLE and ISSUE.
  - IDLE: if the FIFO is non-empty, pop the head at edge E and register its first beat. write_enable=1 after E. Go to ISSUE, or stay in IDLE for a dropped command.
  - Latency: a command pushed at edge E0 into an empty FIFO while IDLE pops at E1. Its first beat is valid E1..E2.
  - ISSUE: one beat per cycle with no gaps. On the final beat's edge, if the FIFO is non-empty, pop and start the next command with no bubble. Otherwise write_enable goes to 0 and the FSM returns to IDLE.
- Expansion:
  - WRITE: 1 beat, position=cmd_pos, value=cmd_value.
  - FILL: NUM_CELLS beats, position 0,1,...,NUM_CELLS-1, value=cmd_value.
  - CLEAR: same as FILL with value=8'h00.
  - FILL_ROW: ROW_CELLS beats, position = {cmd_pos[3:2], 2'b00} + k for k=0..3, value=cmd_value.
- Out-of-range WRITE (cmd_pos >= NUM_CELLS):
  - Popped, no beat issued, err_oor set.
  - Costs one idle cycle in the FSM.
  - err_oor clears only on reset.
- FILL_ROW ignores cmd_pos[7:4]; the row is always in range.
- Beat counter is 8 bits wide with no wrap: terminal count is NUM_CELLS-1 or ROW_CELLS-1.
- busy = FIFO non-empty || write_enable registered high || FSM != IDLE.
- Reset mid-expansion: beats stop immediately (write_enable=0 asynchronously), FIFO is flushed, and the remainder of the command is lost.

Optional Feature:
- Macro: VGA_SEQ_WRITE_COUNT_EN.
- Defined: adds output write_count [15:0]. It is reset to 0, increments on every cycle with write_enable=1, and saturates at 16'hFFFF.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package vga_seq_pkg:
  - opcode constants OP_WRITE=2'b00, OP_FILL=2'b01, OP_CLEAR=2'b10, OP_FILL_ROW=2'b11.
  - FSM state encoding.
  - command record width (2+8+8=18 bits).
- One sub-module: vga_cmd_fifo, a synchronous FIFO with FIFO_DEPTH entries, 18 bits wide, full/empty flags, rst_n async flush.
- The expansion FSM stays in vga_cmd_seq.

Test Plan:
- WRITE pos=5 val=8'hE0 into an idle block -> one beat one cycle after acceptance with position=5, value=E0; busy drops the next cycle.
- FILL val=8'h1C -> 16 consecutive beats, positions 0..15, all value=1C, no gaps.
- Push 5 commands back-to-back (FILL, then four WRITEs) with FIFO_DEPTH=4 -> cmd_ready low after the 4th un-popped entry; total beats 16+4 with no bubble between commands.
- FILL_ROW pos=8'h08 val=8'h03, then CLEAR -> beats at positions 8,9,10,11 value=03, then 16 beats value=00.
- WRITE pos=8'd20 -> no beat, err_oor=1 and held. Follow with WRITE pos=0 -> normal beat, err_oor stays 1.
- Assert rst_n=0 at beat 7 of a FILL with 2 commands queued -> write_enable=0 immediately; after release, no beats, busy=0, cmd_ready=1. With VGA_SEQ_WRITE_COUNT_EN, write_count reads 0.
